// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I and D caches.
// Within a client a pending write-back is always served before that client's fill.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module mem_arbiter #(
   parameter int WIDTH = `MEMORY_WIDTH,
   parameter bit FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_write_req,
   input  logic [31:0]      i_write_addr,
   input  logic [WIDTH-1:0] i_write_data,
   output logic             i_write_ack,
   input  logic             i_read_req,
   input  logic [31:0]      i_read_addr,
   output logic [WIDTH-1:0] i_read_data,
   output logic             i_read_ack,
   input  logic             d_write_req,
   input  logic [31:0]      d_write_addr,
   input  logic [WIDTH-1:0] d_write_data,
   output logic             d_write_ack,
   input  logic             d_read_req,
   input  logic [31:0]      d_read_addr,
   output logic [WIDTH-1:0] d_read_data,
   output logic             d_read_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             busy,
   output logic [1:0]       o_dbg_state
);

   // Handshakes: client reqs are levels held until their one-cycle ack; mem_req is
   // held with stable mem_* until the one-cycle mem_ack, which only counts in WAIT.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_last;     // 1 = D was granted last
   logic             r_client;   // 1 = D owns the current transaction
   logic             r_we;
   logic [31:0]      r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_i_rdata;
   logic [WIDTH-1:0] r_d_rdata;
   logic             w_pend_i;
   logic             w_pend_d;
   logic             w_sel_d;
   logic             w_grant;

   assign w_pend_i = i_write_req | i_read_req;
   assign w_pend_d = d_write_req | d_read_req;
   assign w_sel_d  = w_pend_d & (~w_pend_i | ~r_last);
   assign w_grant  = (r_state == S_IDLE) & (w_pend_i | w_pend_d);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_pend_i | w_pend_d) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (mem_ack) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last    <= ~FIRST;
         r_client  <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_last   <= w_sel_d;
            r_client <= w_sel_d;
            if (w_sel_d) begin
               r_we    <= d_write_req;
               r_addr  <= d_write_req ? d_write_addr : d_read_addr;
               r_wdata <= d_write_data;
            end else begin
               r_we    <= i_write_req;
               r_addr  <= i_write_req ? i_write_addr : i_read_addr;
               r_wdata <= i_write_data;
            end
         end
         if ((r_state == S_WAIT) && mem_ack && !r_we) begin
            if (r_client) r_d_rdata <= mem_rdata;
            else          r_i_rdata <= mem_rdata;
         end
      end
   end

   always_comb begin
      mem_req     = 1'b0;
      busy        = 1'b0;
      i_write_ack = 1'b0;
      i_read_ack  = 1'b0;
      d_write_ack = 1'b0;
      d_read_ack  = 1'b0;
      case (r_state)
         S_ISSUE, S_WAIT: begin
            mem_req = 1'b1;
            busy    = 1'b1;
         end
         S_RESP: begin
            busy        = 1'b1;
            i_write_ack = ~r_client & r_we;
            i_read_ack  = ~r_client & ~r_we;
            d_write_ack = r_client & r_we;
            d_read_ack  = r_client & ~r_we;
         end
         default: ;
      endcase
   end

   assign mem_we      = r_we;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign i_read_data = r_i_rdata;
   assign d_read_data = r_d_rdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic from both clients,
// checked by a transaction-level arbitration model and an expected-response scoreboard.
module tb_mem_arbiter;
   localparam int W = 64;
   localparam bit FIRST_P = 1'b1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_write_req = 0, i_read_req = 0, d_write_req = 0, d_read_req = 0;
   logic [31:0]   i_write_addr = 0, i_read_addr = 0, d_write_addr = 0, d_read_addr = 0;
   logic [W-1:0]  i_write_data = 0, d_write_data = 0;
   logic          i_write_ack, i_read_ack, d_write_ack, d_read_ack;
   logic [W-1:0]  i_read_data, d_read_data;
   logic          mem_req, mem_we;
   logic [31:0]   mem_addr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata = 0;
   logic          mem_ack = 0;
   logic          busy;
   logic [1:0]    o_dbg_state;

   always #5 clk = ~clk;

   mem_arbiter #(.WIDTH(W), .FIRST(FIRST_P)) dut (
      .clk(clk), .reset(reset),
      .i_write_req(i_write_req), .i_write_addr(i_write_addr), .i_write_data(i_write_data),
      .i_write_ack(i_write_ack), .i_read_req(i_read_req), .i_read_addr(i_read_addr),
      .i_read_data(i_read_data), .i_read_ack(i_read_ack),
      .d_write_req(d_write_req), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
      .d_write_ack(d_write_ack), .d_read_req(d_read_req), .d_read_addr(d_read_addr),
      .d_read_data(d_read_data), .d_read_ack(d_read_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .o_dbg_state(o_dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      n_checks++;
      n_fail++;
      $display("FAIL %s: %s", name, why);
   endtask

   // Scoreboard: expected acks {client, write} and expected fill data, in order.
   logic [1:0]   exp_ack_q[$];
   logic [W-1:0] exp_q[$];
   logic [1:0]   grant_log[$];

   // Reference model state.
   bit           m_last;
   logic [W-1:0] m_irdata, m_drdata;
   bit           cur_we;
   logic [31:0]  cur_addr;
   int           n_txn = 0;
   bit           prev_req = 0;
   bit           mem_auto = 0;

   // Client request levels as seen on the grant edge.
   logic         s_iw, s_ir, s_dw, s_dr;
   logic [31:0]  s_iwa, s_ira, s_dwa, s_dra;
   logic [W-1:0] s_iwd, s_dwd;
   always @(posedge clk) begin
      s_iw <= i_write_req; s_ir <= i_read_req; s_dw <= d_write_req; s_dr <= d_read_req;
      s_iwa <= i_write_addr; s_ira <= i_read_addr; s_dwa <= d_write_addr; s_dra <= d_read_addr;
      s_iwd <= i_write_data; s_dwd <= d_write_data;
   end

   bit           mon_pi, mon_pd, mon_sd, mon_we;
   logic [31:0]  mon_a;
   logic [W-1:0] mon_wd, mon_rd;
   logic [3:0]   mon_acks, mon_exp;
   logic [1:0]   mon_k;

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_req && !prev_req) begin
            mon_pi = s_iw | s_ir;
            mon_pd = s_dw | s_dr;
            if (!mon_pi && !mon_pd) fail_now("grant", "mem_req rose with no request pending");
            if (mon_pi && mon_pd) mon_sd = !m_last;
            else                  mon_sd = mon_pd;
            m_last = mon_sd;
            mon_we = mon_sd ? s_dw : s_iw;
            if (mon_sd) begin mon_a = s_dw ? s_dwa : s_dra; mon_wd = s_dwd; end
            else        begin mon_a = s_iw ? s_iwa : s_ira; mon_wd = s_iwd; end
            cur_we = mon_we;
            cur_addr = mon_a;
            check("mem_we", mem_we, mon_we);
            check("mem_addr", mem_addr, mon_a);
            if (mon_we) check("mem_wdata", mem_wdata, mon_wd);
            exp_ack_q.push_back({mon_sd, mon_we});
            grant_log.push_back({mon_sd, mon_we});
            n_txn++;
         end
         mon_acks = {i_write_ack, i_read_ack, d_write_ack, d_read_ack};
         if (mon_acks != 4'd0) begin
            check("ack_count", W'($countones(mon_acks)), 1);
            if (exp_ack_q.size() == 0) begin
               fail_now("ack_unexpected", $sformatf("acks=%b while none expected", mon_acks));
            end else begin
               mon_k = exp_ack_q.pop_front();
               mon_exp = mon_k[1] ? (mon_k[0] ? 4'b0010 : 4'b0001)
                                  : (mon_k[0] ? 4'b1000 : 4'b0100);
               check("ack_which", mon_acks, mon_exp);
               if (!mon_k[0]) begin
                  if (exp_q.size() == 0) fail_now("fill_data", "no fill data expected");
                  else begin
                     mon_rd = exp_q.pop_front();
                     if (mon_k[1]) m_drdata = mon_rd;
                     else          m_irdata = mon_rd;
                  end
               end
               check("i_read_data", i_read_data, m_irdata);
               check("d_read_data", d_read_data, m_drdata);
            end
         end
         prev_req = mem_req;
      end
   end

   // Memory model: random 1..4 cycle latency measured from the ISSUE cycle.
   initial forever begin
      int lat;
      @(negedge clk);
      if (mem_auto && mem_req && !reset) begin
         lat = $urandom_range(1, 4);
         repeat (lat) @(negedge clk);
         check("mem_hold_req", mem_req, 1);
         check("mem_hold_we", mem_we, cur_we);
         check("mem_hold_addr", mem_addr, cur_addr);
         mem_rdata = {$urandom, $urandom};
         mem_ack = 1'b1;
         if (!mem_we) exp_q.push_back(mem_rdata);
         @(negedge clk);
         mem_ack = 1'b0;
      end
   end

   task automatic mem_respond(input int lat, input logic [W-1:0] data);
      int b = 0;
      while (!mem_req && b < 50) begin @(negedge clk); b++; end
      if (!mem_req) fail_now("mem_req_timeout", "mem_req never rose");
      else begin
         repeat (lat) @(negedge clk);
         mem_rdata = data;
         mem_ack = 1'b1;
         if (!mem_we) exp_q.push_back(data);
         @(negedge clk);
         mem_ack = 1'b0;
      end
   endtask

   task automatic set_w(input bit c, input bit v, input logic [31:0] a, input logic [W-1:0] d);
      if (c) begin d_write_req = v; d_write_addr = a; d_write_data = d; end
      else   begin i_write_req = v; i_write_addr = a; i_write_data = d; end
   endtask

   task automatic set_r(input bit c, input bit v, input logic [31:0] a);
      if (c) begin d_read_req = v; d_read_addr = a; end
      else   begin i_read_req = v; i_read_addr = a; end
   endtask

   function automatic bit get_ack(input bit c, input bit w);
      return c ? (w ? d_write_ack : d_read_ack) : (w ? i_write_ack : i_read_ack);
   endfunction

   // Raise the requested channels and drop each one as soon as its ack is seen.
   task automatic client_op(input bit c, input bit do_w, input bit do_r, input logic [31:0] wa,
                            input logic [W-1:0] wd, input logic [31:0] ra);
      int b = 0;
      if (do_w) set_w(c, 1'b1, wa, wd);
      if (do_r) set_r(c, 1'b1, ra);
      while ((do_w || do_r) && b < 300) begin
         @(negedge clk);
         b++;
         if (do_w && get_ack(c, 1'b1)) begin set_w(c, 1'b0, wa, wd); do_w = 0; end
         if (do_r && get_ack(c, 1'b0)) begin set_r(c, 1'b0, ra); do_r = 0; end
      end
      if (do_w || do_r) begin
         fail_now("ack_timeout", $sformatf("client %0d request never acked", c));
         set_w(c, 1'b0, wa, wd);
         set_r(c, 1'b0, ra);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      i_write_req = 0; i_read_req = 0; d_write_req = 0; d_read_req = 0;
      mem_ack = 0;
      @(negedge clk);
      reset = 1'b0;
      exp_ack_q.delete(); exp_q.delete(); grant_log.delete();
      m_last = !FIRST_P; m_irdata = '0; m_drdata = '0; prev_req = 0;
   endtask

   task automatic rand_client(input bit c, input int n);
      int kind;
      repeat (n) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         kind = $urandom_range(1, 3);
         client_op(c, kind[0], kind[1], $urandom & 32'hFFFF_FFC0, {$urandom, $urandom},
                   $urandom & 32'hFFFF_FFC0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int saved;
      int seen;
      int b;
      logic [W-1:0] a5;
      a5 = {W/8{8'hA5}};
      do_reset();

      // Reset values.
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_i_read_data", i_read_data, 0);
      check("rst_d_read_data", d_read_data, 0);
      check("rst_acks", {i_write_ack, i_read_ack, d_write_ack, d_read_ack}, 0);
      check("rst_state", o_dbg_state, 0);

      // Plain I fill of 0x40 with a 3-cycle memory.
      mem_auto = 0;
      fork
         client_op(1'b0, 1'b0, 1'b1, 32'h0, '0, 32'h0000_0040);
         mem_respond(3, a5);
      join
      check("t1_mem_we", mem_we, 0);
      check("t1_mem_addr", mem_addr, 32'h40);
      check("t1_i_read_data", i_read_data, a5);
      check("t1_d_read_data", d_read_data, 0);

      // Spurious mem_ack while idle.
      repeat (2) @(negedge clk);
      mem_rdata = {$urandom, $urandom};
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("t6_state", o_dbg_state, 0);
      check("t6_busy", busy, 0);
      @(negedge clk);
      check("t6_i_read_data", i_read_data, a5);
      check("t6_d_read_data", d_read_data, 0);

      // Reset while waiting on memory; the late mem_ack must be discarded.
      set_r(1'b0, 1'b1, 32'h0000_0080);
      b = 0;
      while (!mem_req && b < 20) begin @(negedge clk); b++; end
      @(negedge clk);
      check("t4_busy_wait", busy, 1);
      check("t4_state_wait", o_dbg_state, 2);
      do_reset();
      @(negedge clk);
      mem_rdata = {$urandom, $urandom};
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("t4_mem_req", mem_req, 0);
      check("t4_state", o_dbg_state, 0);
      check("t4_i_read_data", i_read_data, 0);
      check("t4_acks", {i_write_ack, i_read_ack, d_write_ack, d_read_ack}, 0);
      mem_auto = 1;
      client_op(1'b0, 1'b0, 1'b1, 32'h0, '0, 32'h0000_00C0);

      // D write and read raised together: write goes first.
      grant_log.delete();
      client_op(1'b1, 1'b1, 1'b1, 32'h0000_0100, {$urandom, $urandom}, 32'h0000_0200);
      check("t2_n_grants", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         check("t2_first", grant_log[0], 2'b11);
         check("t2_second", grant_log[1], 2'b10);
      end
      check("t2_mem_addr", mem_addr, 32'h200);

      // Continuous contention after reset: D, I, D, I, D, I.
      do_reset();
      fork
         repeat (3) client_op(1'b0, 1'b0, 1'b1, 32'h0, '0, $urandom & 32'hFFFF_FFC0);
         repeat (3) client_op(1'b1, 1'b0, 1'b1, 32'h0, '0, $urandom & 32'hFFFF_FFC0);
      join
      check("t3_n_grants", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++)
         check($sformatf("t3_grant%0d", i), grant_log[i][1], (i % 2 == 0) ? 1 : 0);

      // Request dropped after grant still completes.
      mem_auto = 0;
      set_r(1'b0, 1'b1, 32'h0000_0300);
      fork
         begin
            b = 0;
            while (!mem_req && b < 20) begin @(negedge clk); b++; end
            @(negedge clk);
            set_r(1'b0, 1'b0, 32'h0000_0300);
         end
         mem_respond(3, {$urandom, $urandom});
      join
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (i_read_ack) seen++;
         @(negedge clk);
      end
      check("t5_dropped_ack", seen, 1);

      // Request raised and dropped while busy is never granted.
      saved = n_txn;
      fork
         client_op(1'b1, 1'b0, 1'b1, 32'h0, '0, 32'h0000_0400);
         begin
            b = 0;
            while (!mem_req && b < 20) begin @(negedge clk); b++; end
            @(negedge clk);
            set_r(1'b0, 1'b1, 32'h0000_0500);
            @(negedge clk);
            set_r(1'b0, 1'b0, 32'h0000_0500);
         end
         mem_respond(4, {$urandom, $urandom});
      join
      repeat (8) @(negedge clk);
      check("t5_no_grant", n_txn - saved, 1);
      check("t5_mem_req", mem_req, 0);

      // Random traffic from both clients.
      mem_auto = 1;
      fork
         rand_client(1'b0, 20);
         rand_client(1'b1, 20);
      join
      repeat (10) @(negedge clk);
      check("end_ack_q_empty", exp_ack_q.size(), 0);
      check("end_data_q_empty", exp_q.size(), 0);
      check("end_idle", o_dbg_state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
